instr_fetch_latch: RTL and testbench

//  Sits between the ROM nibble output and decoderWithCc. Captures OPR at M1 and OPA at M2,

---
 rtl/tb4004_pkg.sv | 37 +++
 rtl/instr_fetch_latch.sv | 139 +++++++++++++
 tb/tb_instr_fetch_latch.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/tb4004_pkg.sv
// ----------------------------------------------------------------------------
// tb4004_pkg
// Shared definitions for the 4004-style fetch path:
//   - CYC_*      : 3-bit machine-cycle encodings (A1..A3, M1, M2, X1..X3)
//   - OPR_*      : opcodes whose instructions occupy two ROM words
//   - fetch_state_e : fetch FSM states (first word / second word)
//   - isTwoWord  : classifies an OPR/OPA pair as a two-word instruction
// ----------------------------------------------------------------------------
package tb4004_pkg;

    localparam logic [2:0] CYC_A1 = 3'd0;
    localparam logic [2:0] CYC_A2 = 3'd1;
    localparam logic [2:0] CYC_A3 = 3'd2;
    localparam logic [2:0] CYC_M1 = 3'd3;
    localparam logic [2:0] CYC_M2 = 3'd4;
    localparam logic [2:0] CYC_X1 = 3'd5;
    localparam logic [2:0] CYC_X2 = 3'd6;
    localparam logic [2:0] CYC_X3 = 3'd7;

    localparam logic [3:0] OPR_JCN     = 4'h1;
    localparam logic [3:0] OPR_FIM_SRC = 4'h2;
    localparam logic [3:0] OPR_JUN     = 4'h4;
    localparam logic [3:0] OPR_JMS     = 4'h5;
    localparam logic [3:0] OPR_ISZ     = 4'h7;

    typedef enum logic {
        FETCH1 = 1'b0,
        FETCH2 = 1'b1
    } fetch_state_e;

    // FIM and SRC share OPR 2; only the even OPA (FIM) carries a second word.
    function automatic logic isTwoWord(input logic [3:0] opr, input logic [3:0] opa);
        return (opr == OPR_JCN) || (opr == OPR_JUN) || (opr == OPR_JMS) ||
               (opr == OPR_ISZ) || ((opr == OPR_FIM_SRC) && !opa[0]);
    endfunction

endpackage

// File: rtl/instr_fetch_latch.sv
// ----------------------------------------------------------------------------
// instr_fetch_latch
// Captures the instruction nibbles from ROM and presents a stable
// opr/opa/imm8 to the decoder, with an instrValid window over X1..X3 of the
// final word of each instruction. Two-word instructions have their second
// word collected into imm8. A sticky seqError flags any clock where the
// machine-cycle counter did not advance by exactly one (mod 8).
//
// Ports
//   clk         in   CPU clock
//   rst         in   asynchronous, active-high reset
//   cycle[2:0]  in   machine cycle (0=A1 .. 3=M1, 4=M2 .. 7=X3)
//   romData[3:0]in   ROM nibble, meaningful at M1/M2
//   opr[3:0]    out  first-word OPR
//   opa[3:0]    out  first-word OPA
//   imm8[7:0]   out  second word {M1 nibble, M2 nibble}
//   twoWord     out  latched opcode is a two-word instruction
//   secondWord  out  second word is being fetched
//   instrValid  out  complete instruction present (X1..X3 of final word)
//   seqError    out  sticky cycle-sequence error
// ----------------------------------------------------------------------------
module instr_fetch_latch
    import tb4004_pkg::*;
#(
    parameter logic [3:0] RST_OPR   = 4'h0,
    parameter logic [3:0] RST_OPA   = 4'h0,
    parameter bit         CHECK_SEQ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cycle,
    input  logic [3:0] romData,
    output logic [3:0] opr,
    output logic [3:0] opa,
    output logic [7:0] imm8,
    output logic       twoWord,
    output logic       secondWord,
    output logic       instrValid,
    output logic       seqError
);

    fetch_state_e state_q;
    logic [2:0]   prev_cycle_q;
    logic         prev_valid_q;
    logic [3:0]   opr_q;
    logic [3:0]   opa_q;
    logic [7:0]   imm8_q;
    logic         two_word_q;
    logic         second_word_q;
    logic         instr_valid_q;
    logic         seq_error_q;

    logic [2:0]   expect_cycle_d;
    logic         seq_bad_d;
    logic         two_word_d;

    // Wraps 7 -> 0 naturally in 3 bits.
    assign expect_cycle_d = prev_cycle_q + 3'd1;

    // The first edge after reset only seeds prev_cycle_q, so it is never flagged.
    assign seq_bad_d  = CHECK_SEQ && prev_valid_q && (cycle != expect_cycle_d);

    // Classifies against the OPA arriving now, since opa_q updates on this edge.
    assign two_word_d = isTwoWord(opr_q, romData);

    // Fetch FSM: state, secondWord, instrValid window and sequence checker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH1;
            second_word_q <= 1'b0;
            instr_valid_q <= 1'b0;
            seq_error_q   <= 1'b0;
            prev_cycle_q  <= 3'd0;
            prev_valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values, so ordering inside this block does not matter.
            prev_cycle_q <= cycle;
            prev_valid_q <= 1'b1;

            if (seq_bad_d) begin
                // A broken sequence abandons the instruction in flight.
                seq_error_q   <= 1'b1;
                state_q       <= FETCH1;
                second_word_q <= 1'b0;
                instr_valid_q <= 1'b0;
            end else begin
                if (cycle == CYC_M2 && (state_q == FETCH2 || !two_word_d)) begin
                    instr_valid_q <= 1'b1;
                end

                if (cycle == CYC_X3) begin
                    instr_valid_q <= 1'b0;
                    if (state_q == FETCH1 && two_word_q) begin
                        state_q       <= FETCH2;
                        second_word_q <= 1'b1;
                    end else if (state_q == FETCH2) begin
                        state_q       <= FETCH1;
                        second_word_q <= 1'b0;
                    end
                end
            end
        end
    end

    // Instruction latches: first word into opr/opa, second word into imm8.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opr_q      <= RST_OPR;
            opa_q      <= RST_OPA;
            imm8_q     <= 8'h00;
            two_word_q <= 1'b0;
        end else if (!seq_bad_d) begin
            if (cycle == CYC_M1) begin
                if (state_q == FETCH1) begin
                    opr_q <= romData;
                end else begin
                    imm8_q[7:4] <= romData;
                end
            end else if (cycle == CYC_M2) begin
                if (state_q == FETCH1) begin
                    opa_q      <= romData;
                    two_word_q <= two_word_d;
                end else begin
                    imm8_q[3:0] <= romData;
                end
            end
        end
    end

    assign opr        = opr_q;
    assign opa        = opa_q;
    assign imm8       = imm8_q;
    assign twoWord    = two_word_q;
    assign secondWord = second_word_q;
    assign instrValid = instr_valid_q;
    assign seqError   = seq_error_q;

endmodule

// File: tb/tb_instr_fetch_latch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_latch
// Directed bench for instr_fetch_latch: a per-clock vector table for the
// normal instruction stream, plus hand-written sequences for reset during a
// second-word fetch and for cycle-sequence errors.
// ----------------------------------------------------------------------------
module tb_instr_fetch_latch;

    logic       clk;
    logic       rst;
    logic [2:0] cycle;
    logic [3:0] romData;
    logic [3:0] opr;
    logic [3:0] opa;
    logic [7:0] imm8;
    logic       twoWord;
    logic       secondWord;
    logic       instrValid;
    logic       seqError;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_latch dut (
        .clk        (clk),
        .rst        (rst),
        .cycle      (cycle),
        .romData    (romData),
        .opr        (opr),
        .opa        (opa),
        .imm8       (imm8),
        .twoWord    (twoWord),
        .secondWord (secondWord),
        .instrValid (instrValid),
        .seqError   (seqError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; expected values are the state after that edge.
    typedef struct {
        logic [2:0] cyc;
        logic [3:0] data;
        logic [3:0] opr;
        logic [3:0] opa;
        logic [7:0] imm;
        logic       tw;
        logic       sw;
        logic       iv;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_opr, input logic [3:0] e_opa,
                             input logic [7:0] e_imm, input logic e_tw, input logic e_sw,
                             input logic e_iv, input logic e_se);
        check({tag, ".opr"},        {4'h0, opr},        {4'h0, e_opr});
        check({tag, ".opa"},        {4'h0, opa},        {4'h0, e_opa});
        check({tag, ".imm8"},       imm8,               e_imm);
        check({tag, ".twoWord"},    {7'h0, twoWord},    {7'h0, e_tw});
        check({tag, ".secondWord"}, {7'h0, secondWord}, {7'h0, e_sw});
        check({tag, ".instrValid"}, {7'h0, instrValid}, {7'h0, e_iv});
        check({tag, ".seqError"},   {7'h0, seqError},   {7'h0, e_se});
    endtask

    task automatic step(input logic [2:0] c, input logic [3:0] d);
        cycle   = c;
        romData = d;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [2:0] c, input logic [3:0] d, input logic [3:0] e_opr,
                                input logic [3:0] e_opa, input logic [7:0] e_imm,
                                input logic e_tw, input logic e_sw, input logic e_iv);
        vec_t v;
        v.cyc = c; v.data = d; v.opr = e_opr; v.opa = e_opa;
        v.imm = e_imm; v.tw = e_tw; v.sw = e_sw; v.iv = e_iv;
        vecs.push_back(v);
    endfunction

    // n consecutive cycles from c0 with romData 0 and unchanging expectations.
    function automatic void add_run(input logic [2:0] c0, input int n, input logic [3:0] e_opr,
                                    input logic [3:0] e_opa, input logic [7:0] e_imm,
                                    input logic e_tw, input logic e_sw, input logic e_iv);
        for (int i = 0; i < n; i++) begin
            add(3'(c0 + 3'(i)), 4'h0, e_opr, e_opa, e_imm, e_tw, e_sw, e_iv);
        end
    endfunction

    initial begin
        // LDM 5 (D,5): single word, valid X1..X3.
        add_run(3'd0, 3, 4'h0, 4'h0, 8'h00, 0, 0, 0);
        add(3'd3, 4'hD, 4'hD, 4'h0, 8'h00, 0, 0, 0);
        add(3'd4, 4'h5, 4'hD, 4'h5, 8'h00, 0, 0, 1);
        add_run(3'd5, 2, 4'hD, 4'h5, 8'h00, 0, 0, 1);
        add(3'd7, 4'h0, 4'hD, 4'h5, 8'h00, 0, 0, 0);
        // JUN 0x43 / 0xAB.
        add_run(3'd0, 3, 4'hD, 4'h5, 8'h00, 0, 0, 0);
        add(3'd3, 4'h4, 4'h4, 4'h5, 8'h00, 0, 0, 0);
        add(3'd4, 4'h3, 4'h4, 4'h3, 8'h00, 1, 0, 0);
        add_run(3'd5, 2, 4'h4, 4'h3, 8'h00, 1, 0, 0);
        add(3'd7, 4'h0, 4'h4, 4'h3, 8'h00, 1, 1, 0);
        add_run(3'd0, 3, 4'h4, 4'h3, 8'h00, 1, 1, 0);
        add(3'd3, 4'hA, 4'h4, 4'h3, 8'hA0, 1, 1, 0);
        add(3'd4, 4'hB, 4'h4, 4'h3, 8'hAB, 1, 1, 1);
        add_run(3'd5, 2, 4'h4, 4'h3, 8'hAB, 1, 1, 1);
        add(3'd7, 4'h0, 4'h4, 4'h3, 8'hAB, 1, 0, 0);
        // FIM (2,2) / 0x17.
        add_run(3'd0, 3, 4'h4, 4'h3, 8'hAB, 1, 0, 0);
        add(3'd3, 4'h2, 4'h2, 4'h3, 8'hAB, 1, 0, 0);
        add(3'd4, 4'h2, 4'h2, 4'h2, 8'hAB, 1, 0, 0);
        add_run(3'd5, 2, 4'h2, 4'h2, 8'hAB, 1, 0, 0);
        add(3'd7, 4'h0, 4'h2, 4'h2, 8'hAB, 1, 1, 0);
        add_run(3'd0, 3, 4'h2, 4'h2, 8'hAB, 1, 1, 0);
        add(3'd3, 4'h1, 4'h2, 4'h2, 8'h1B, 1, 1, 0);
        add(3'd4, 4'h7, 4'h2, 4'h2, 8'h17, 1, 1, 1);
        add_run(3'd5, 2, 4'h2, 4'h2, 8'h17, 1, 1, 1);
        add(3'd7, 4'h0, 4'h2, 4'h2, 8'h17, 1, 0, 0);
        // SRC (2,3): single word, imm8 untouched.
        add_run(3'd0, 3, 4'h2, 4'h2, 8'h17, 1, 0, 0);
        add(3'd3, 4'h2, 4'h2, 4'h2, 8'h17, 1, 0, 0);
        add(3'd4, 4'h3, 4'h2, 4'h3, 8'h17, 0, 0, 1);
        add_run(3'd5, 2, 4'h2, 4'h3, 8'h17, 0, 0, 1);
        add(3'd7, 4'h0, 4'h2, 4'h3, 8'h17, 0, 0, 0);
        // JMS (5,1) / 0x00.
        add_run(3'd0, 3, 4'h2, 4'h3, 8'h17, 0, 0, 0);
        add(3'd3, 4'h5, 4'h5, 4'h3, 8'h17, 0, 0, 0);
        add(3'd4, 4'h1, 4'h5, 4'h1, 8'h17, 1, 0, 0);
        add_run(3'd5, 2, 4'h5, 4'h1, 8'h17, 1, 0, 0);
        add(3'd7, 4'h0, 4'h5, 4'h1, 8'h17, 1, 1, 0);
        add_run(3'd0, 3, 4'h5, 4'h1, 8'h17, 1, 1, 0);
        add(3'd3, 4'h0, 4'h5, 4'h1, 8'h07, 1, 1, 0);
        add(3'd4, 4'h0, 4'h5, 4'h1, 8'h00, 1, 1, 1);
        add_run(3'd5, 2, 4'h5, 4'h1, 8'h00, 1, 1, 1);
        add(3'd7, 4'h0, 4'h5, 4'h1, 8'h00, 1, 0, 0);
        // ISZ (7,2) / 0xFE, back to back.
        add_run(3'd0, 3, 4'h5, 4'h1, 8'h00, 1, 0, 0);
        add(3'd3, 4'h7, 4'h7, 4'h1, 8'h00, 1, 0, 0);
        add(3'd4, 4'h2, 4'h7, 4'h2, 8'h00, 1, 0, 0);
        add_run(3'd5, 2, 4'h7, 4'h2, 8'h00, 1, 0, 0);
        add(3'd7, 4'h0, 4'h7, 4'h2, 8'h00, 1, 1, 0);
        add_run(3'd0, 3, 4'h7, 4'h2, 8'h00, 1, 1, 0);
        add(3'd3, 4'hF, 4'h7, 4'h2, 8'hF0, 1, 1, 0);
        add(3'd4, 4'hE, 4'h7, 4'h2, 8'hFE, 1, 1, 1);
        add_run(3'd5, 2, 4'h7, 4'h2, 8'hFE, 1, 1, 1);
        add(3'd7, 4'h0, 4'h7, 4'h2, 8'hFE, 1, 0, 0);

        // Reset state.
        rst = 1'b1; cycle = 3'd7; romData = 4'h0;
        @(posedge clk); #1;
        check_out("reset", 4'h0, 4'h0, 8'h00, 0, 0, 0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].cyc, vecs[i].data);
            check_out($sformatf("vec%0d", i), vecs[i].opr, vecs[i].opa, vecs[i].imm,
                      vecs[i].tw, vecs[i].sw, vecs[i].iv, 1'b0);
        end

        // Reset asserted mid-FETCH2 of a JUN, then a single-word instruction.
        for (int c = 0; c < 3; c++) step(3'(c), 4'h0);
        step(3'd3, 4'h4);
        step(3'd4, 4'h3);
        step(3'd5, 4'h0); step(3'd6, 4'h0); step(3'd7, 4'h0);
        check_out("jun_w1_x3", 4'h4, 4'h3, 8'hFE, 1, 1, 0, 0);
        for (int c = 0; c < 3; c++) step(3'(c), 4'h0);
        step(3'd3, 4'h9);
        check_out("jun_w2_m1", 4'h4, 4'h3, 8'h9E, 1, 1, 0, 0);
        cycle = 3'd4;
        #2 rst = 1'b1;
        #1 check_out("async_rst", 4'h0, 4'h0, 8'h00, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        // First edge after release only seeds: 6 after a pre-reset 4 is not an error.
        step(3'd6, 4'h0);
        step(3'd7, 4'h0);
        check_out("post_rst_seed", 4'h0, 4'h0, 8'h00, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) step(3'(c), 4'h0);
        step(3'd3, 4'hF);
        step(3'd4, 4'h2);
        check_out("post_rst_word", 4'hF, 4'h2, 8'h00, 0, 0, 1, 0);
        step(3'd5, 4'h0); step(3'd6, 4'h0); step(3'd7, 4'h0);
        check_out("post_rst_x3", 4'hF, 4'h2, 8'h00, 0, 0, 0, 0);

        // Cycle sequence 2,3,5 in FETCH1.
        for (int c = 0; c < 3; c++) step(3'(c), 4'h0);
        step(3'd3, 4'h8);
        step(3'd5, 4'h1);
        check_out("seq_skip", 4'h8, 4'h2, 8'h00, 0, 0, 0, 1);
        step(3'd6, 4'h0); step(3'd7, 4'h0);
        for (int c = 0; c < 3; c++) step(3'(c), 4'h0);
        step(3'd3, 4'hD);
        step(3'd4, 4'h6);
        check_out("seq_resume", 4'hD, 4'h6, 8'h00, 0, 0, 1, 1);
        // A jump from M2 straight to X3 kills the valid window; nothing latches.
        step(3'd7, 4'h9);
        check_out("seq_kill_iv", 4'hD, 4'h6, 8'h00, 0, 0, 0, 1);

        // Sequence error during FETCH2 drops secondWord.
        for (int c = 0; c < 3; c++) step(3'(c), 4'h0);
        step(3'd3, 4'h4);
        step(3'd4, 4'h3);
        step(3'd5, 4'h0); step(3'd6, 4'h0); step(3'd7, 4'h0);
        check_out("seq_f2_enter", 4'h4, 4'h3, 8'h00, 1, 1, 0, 1);
        for (int c = 0; c < 3; c++) step(3'(c), 4'h0);
        step(3'd3, 4'h9);
        step(3'd5, 4'h0);
        check_out("seq_f2_abort", 4'h4, 4'h3, 8'h90, 1, 0, 0, 1);

        // Only reset clears the sticky error.
        rst = 1'b1;
        @(posedge clk); #1;
        check_out("seq_rst_clear", 4'h0, 4'h0, 8'h00, 0, 0, 0, 0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
